wb_led_matrix_ctrl: RTL and testbench

Wishbone register block and Wishbone master that periodically streams an 8x8 LED-matrix frame (MAX7219-style 16-bit commands) to the SPI Wishbone peripheral. It sits between the CPU data bus and the SPI peripheral's slave port. The CPU writes row data and control over the slave port; the block issues the initialisation and row commands on the master port without CPU involvement.

---
 rtl/wb_led_matrix_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_wb_led_matrix_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_led_matrix_ctrl.sv
// Wishbone register block plus master that streams MAX7219-style 8x8 frames to the SPI peripheral.
// Optional LED_MATRIX_TEST_EN adds the writable CTRL test bit and the display-test command.
module wb_led_matrix_ctrl #(
  parameter logic [31:0] MATRIX_ADR     = 32'h0600_0000,
  parameter int unsigned REFRESH_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

`ifdef LED_MATRIX_TEST_EN
  localparam int unsigned NCMD = 13;
`else
  localparam int unsigned NCMD = 12;
`endif
  localparam logic [3:0]  LAST_IDX = 4'(NCMD - 1);
  localparam logic [23:0] REF_LAST = 24'(REFRESH_CYCLES - 1);

  logic        s_ack_q, s_ack_d;
  logic [31:0] s_dat_q, s_dat_d;
  logic        enable_q, enable_d;
  logic        start_q, start_d;
  logic [3:0]  inten_q, inten_d;
  logic [31:0] rows0_q, rows0_d, rows1_q, rows1_d;
  logic [23:0] ref_cnt_q, ref_cnt_d;
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        stb_q, stb_d;
  logic [15:0] cmd_q, cmd_d;
  logic [63:0] sh_rows_q, sh_rows_d;
  logic [3:0]  sh_inten_q, sh_inten_d;
  logic        pend_q, pend_d;
  logic        pend_st_q, pend_st_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        test_rd;
`ifdef LED_MATRIX_TEST_EN
  logic        test_q, test_d, sh_test_q, sh_test_d;
  assign test_rd = test_q;
`else
  assign test_rd = 1'b0;
`endif

  logic        acc, wr, busy, expire, trig;
  logic [31:0] rd_data;
  logic [3:0]  nidx, j, k;
  logic [7:0]  row;
  logic [15:0] nxt_cmd;

  wire unused_ok = &{1'b0, s_sel_i, s_adr_i[31:4], s_adr_i[1:0]};

  assign busy = (state_q != IDLE);

  // Slave port: single-cycle ack, register writes land on the ack edge
  always_comb begin
    acc      = s_stb_i & s_cyc_i & ~s_ack_q;
    wr       = acc & s_we_i;
    s_ack_d  = acc;
    s_dat_d  = s_dat_q;
    enable_d = enable_q;
    start_d  = 1'b0;
    inten_d  = inten_q;
    rows0_d  = rows0_q;
    rows1_d  = rows1_q;
`ifdef LED_MATRIX_TEST_EN
    test_d   = test_q;
`endif
    case (s_adr_i[3:2])
      2'd0:    rd_data = {20'b0, inten_q, 5'b0, test_rd, 1'b0, enable_q};
      2'd1:    rd_data = {16'b0, frame_cnt_q, 6'b0, pend_q, busy};
      2'd2:    rd_data = rows0_q;
      default: rd_data = rows1_q;
    endcase
    if (acc && !s_we_i) s_dat_d = rd_data;
    if (wr) begin
      case (s_adr_i[3:2])
        2'd0: begin
          enable_d = s_dat_i[0];
          start_d  = s_dat_i[1];
          inten_d  = s_dat_i[11:8];
`ifdef LED_MATRIX_TEST_EN
          test_d   = s_dat_i[2];
`endif
        end
        2'd2:    rows0_d = s_dat_i;
        2'd3:    rows1_d = s_dat_i;
        default: ;
      endcase
    end
  end

  // Refresh timer: free-runs only while enabled, one trigger per REFRESH_CYCLES
  always_comb begin
    expire    = enable_q && (ref_cnt_q == REF_LAST);
    ref_cnt_d = (!enable_q || expire) ? 24'd0 : ref_cnt_q + 24'd1;
    trig      = start_q | expire;
  end

  // Next command in the sequence, taken from the frame shadow copy
  always_comb begin
    nidx = idx_q + 4'd1;
    j    = nidx;
`ifdef LED_MATRIX_TEST_EN
    if (nidx > 4'd1) j = nidx - 4'd1;
`endif
    k   = j - 4'd4;
    row = sh_rows_q[{k[2:0], 3'b000} +: 8];
    case (j)
      4'd0:    nxt_cmd = 16'h0C01;
      4'd1:    nxt_cmd = 16'h0900;
      4'd2:    nxt_cmd = 16'h0B07;
      4'd3:    nxt_cmd = {8'h0A, 4'h0, sh_inten_q};
      default: nxt_cmd = {4'h0, j - 4'd3, row};
    endcase
`ifdef LED_MATRIX_TEST_EN
    if (nidx == 4'd1) nxt_cmd = {8'h0F, 7'b0, sh_test_q};
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stb_d       = stb_q;
    cmd_d       = cmd_q;
    sh_rows_d   = sh_rows_q;
    sh_inten_d  = sh_inten_q;
    pend_d      = pend_q;
    pend_st_d   = pend_st_q;
    frame_cnt_d = frame_cnt_q;
`ifdef LED_MATRIX_TEST_EN
    sh_test_d   = sh_test_q;
`endif
    case (state_q)
      IDLE: if (trig || pend_q) begin
        state_d    = REQ;
        stb_d      = 1'b1;
        idx_d      = 4'd0;
        cmd_d      = 16'h0C01;
        sh_rows_d  = {rows1_q, rows0_q};
        sh_inten_d = inten_q;
`ifdef LED_MATRIX_TEST_EN
        sh_test_d  = test_q;
`endif
        pend_d     = 1'b0;
        pend_st_d  = 1'b0;
      end
      REQ: if (m_ack_i) begin
        state_d = GAP;
        stb_d   = 1'b0;
        if (idx_q == LAST_IDX) frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default: begin
        if (idx_q == LAST_IDX) state_d = IDLE;
        else begin
          state_d = REQ;
          stb_d   = 1'b1;
          idx_d   = nidx;
          cmd_d   = nxt_cmd;
        end
      end
    endcase
    // One frame can queue; a start-write request outlives a disable, a timer one does not
    if (busy) begin
      if (trig) begin
        pend_d = 1'b1;
        if (start_q) pend_st_d = 1'b1;
      end else if (!enable_q && !pend_st_q) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_q     <= 1'b0;
      s_dat_q     <= 32'd0;
      enable_q    <= 1'b0;
      start_q     <= 1'b0;
      inten_q     <= 4'd0;
      rows0_q     <= 32'd0;
      rows1_q     <= 32'd0;
      ref_cnt_q   <= 24'd0;
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      stb_q       <= 1'b0;
      cmd_q       <= 16'd0;
      sh_rows_q   <= 64'd0;
      sh_inten_q  <= 4'd0;
      pend_q      <= 1'b0;
      pend_st_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
`ifdef LED_MATRIX_TEST_EN
      test_q      <= 1'b0;
      sh_test_q   <= 1'b0;
`endif
    end else begin
      s_ack_q     <= s_ack_d;
      s_dat_q     <= s_dat_d;
      enable_q    <= enable_d;
      start_q     <= start_d;
      inten_q     <= inten_d;
      rows0_q     <= rows0_d;
      rows1_q     <= rows1_d;
      ref_cnt_q   <= ref_cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      stb_q       <= stb_d;
      cmd_q       <= cmd_d;
      sh_rows_q   <= sh_rows_d;
      sh_inten_q  <= sh_inten_d;
      pend_q      <= pend_d;
      pend_st_q   <= pend_st_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef LED_MATRIX_TEST_EN
      test_q      <= test_d;
      sh_test_q   <= sh_test_d;
`endif
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_adr_o = MATRIX_ADR;
  assign m_dat_o = {16'b0, cmd_q};
  assign m_we_o  = 1'b1;
  assign m_sel_o = 4'b0011;
  assign m_stb_o = stb_q;
  assign m_cyc_o = stb_q;

endmodule

// File: tb/tb_wb_led_matrix_ctrl.sv
// Directed bench for wb_led_matrix_ctrl: register vector table, frame command table,
// and hand-written sequences for shadowing, pending, reset and refresh behaviour.
module tb_wb_led_matrix_ctrl;

`ifdef LED_MATRIX_TEST_EN
  localparam int NX = 13;
  localparam logic [31:0] CTRL_RB = 32'h0000_0F04;
`else
  localparam int NX = 12;
  localparam logic [31:0] CTRL_RB = 32'h0000_0F00;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_adr_i = '0, s_dat_i = '0;
  logic        s_we_i = 1'b0, s_stb_i = 1'b0, s_cyc_i = 1'b0;
  logic [3:0]  s_sel_i = '0;
  logic        s_ack_o;
  logic [31:0] s_dat_o, m_adr_o, m_dat_o;
  logic        m_we_o, m_stb_o, m_cyc_o;
  logic [3:0]  m_sel_o;
  logic        m_ack_i = 1'b0;

  wb_led_matrix_ctrl #(.MATRIX_ADR(32'h0600_0000), .REFRESH_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int ack_delay = 0;
  int xfers = 0;
  int cyc = 0;
  logic [15:0] got[$];
  int fstarts[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave responder: ack after ack_delay cycles of strobe
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (m_stb_o && !m_ack_i) begin
        if (wcnt >= ack_delay) begin m_ack_i = 1'b1; wcnt = 0; end
        else wcnt++;
      end else begin
        m_ack_i = 1'b0;
        if (!m_stb_o) wcnt = 0;
      end
    end
  end

  // Bus monitor: records transfers, checks constant fields, REQ stability and gap width
  initial begin
    int low_run = 0;
    logic prev_stb = 1'b0;
    logic [31:0] prev_dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        xfers = 0; low_run = 0; prev_stb = 1'b0;
        got.delete(); fstarts.delete();
      end else begin
        if (m_stb_o) begin
          if (!prev_stb) begin
            if (xfers % NX == 0) fstarts.push_back(cyc);
            else chk("gap_width", low_run, 1);
          end else begin
            chk("dat_stable", m_dat_o, prev_dat);
          end
          if (m_ack_i) begin
            got.push_back(m_dat_o[15:0]);
            chk("m_adr", m_adr_o, 32'h0600_0000);
            chk("m_sel", {28'b0, m_sel_o}, 32'h3);
            chk("m_we_cyc", {30'b0, m_we_o, m_cyc_o}, 32'h3);
            chk("m_dat_hi", {16'b0, m_dat_o[31:16]}, 32'h0);
            xfers++;
          end
          low_run = 0;
        end else begin
          low_run++;
        end
        prev_stb = m_stb_o;
        prev_dat = m_dat_o;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic we,
                     output logic [31:0] rd);
    int n = 0;
    s_adr_i = {28'h0, a, 2'b00}; s_dat_i = d; s_we_i = we; s_sel_i = 4'hF;
    s_stb_i = 1'b1; s_cyc_i = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!s_ack_o && n < 20);
    chk("bus_ack", {31'b0, s_ack_o}, 32'h1);
    rd = s_dat_o;
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, d, 1'b1, dummy);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(a, 32'h0, 1'b0, v);
    chk(nm, v, exp);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfers < target && n < budget) begin @(posedge clk); #1; n++; end
    chk("xfer_reach", xfers, target);
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  wadr;
    logic [31:0] wdat;
    logic [1:0]  radr;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vt[7];
    logic [15:0] exp_fr[13];
    logic [31:0] st;
    int          base;

    vt[0] = '{"rows0_rw",    2'd2, 32'hA5A5_1234, 2'd2, 32'hA5A5_1234};
    vt[1] = '{"rows1_rw",    2'd3, 32'h0102_0304, 2'd3, 32'h0102_0304};
    vt[2] = '{"ctrl_mask",   2'd0, 32'hFFFF_FFFC, 2'd0, CTRL_RB};
    vt[3] = '{"status_ro",   2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0};
    vt[4] = '{"ctrl_keep",   2'd1, 32'hFFFF_FFFF, 2'd0, CTRL_RB};
    vt[5] = '{"ctrl_clr",    2'd0, 32'h0,         2'd0, 32'h0};
    vt[6] = '{"rows1_keep",  2'd2, 32'h0,         2'd3, 32'h0102_0304};

`ifdef LED_MATRIX_TEST_EN
    exp_fr = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A03, 16'h0111, 16'h0222,
               16'h0333, 16'h0444, 16'h0555, 16'h0666, 16'h0777, 16'h0888};
`else
    exp_fr = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A03, 16'h0111, 16'h0222, 16'h0333,
               16'h0444, 16'h0555, 16'h0666, 16'h0777, 16'h0888, 16'h0000};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, s_ack_o}, 32'h0);
    chk("rst_stb", {31'b0, m_stb_o}, 32'h0);
    rst_n = 1'b1;
    idle(1);
    chk("rst_sdat", s_dat_o, 32'h0);
    chk("rst_mdat", m_dat_o, 32'h0);
    chk("rst_cyc", {31'b0, m_cyc_o}, 32'h0);
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_status", 2'd1, 32'h0);
    rd_chk("rst_rows0", 2'd2, 32'h0);
    rd_chk("rst_rows1", 2'd3, 32'h0);

    // Register vectors
    for (int i = 0; i < 7; i++) begin
      wr(vt[i].wadr, vt[i].wdat);
      rd_chk(vt[i].nm, vt[i].radr, vt[i].exp);
    end
    idle(5);
    chk("no_frame_from_regs", xfers, 0);

    // Basic frame with zero-wait acks
    ack_delay = 0;
    wr(2'd2, 32'h4433_2211);
    wr(2'd3, 32'h8877_6655);
    wr(2'd0, 32'h0000_0302);
    chk("pre_start_stb", {31'b0, m_stb_o}, 32'h0);
    idle(1);
    chk("start_latency", {31'b0, m_stb_o}, 32'h1);
    wait_xfers(NX, 200);
    idle(4);
    for (int i = 0; i < NX; i++) chk($sformatf("frame1_cmd%0d", i), {16'b0, got[i]}, {16'b0, exp_fr[i]});
    rd_chk("status_f1", 2'd1, 32'h0000_0100);

    // Slow acks, rows rewritten mid-frame only affect the next frame
    ack_delay = 40;
    base = xfers;
    wr(2'd0, 32'h0000_0302);
    begin
      int n = 0;
      while (xfers < base + 3 && n < 500) begin @(posedge clk); #1; n++; end
    end
    wr(2'd2, 32'hFFFF_FFFF);
    wait_xfers(base + NX, 1500);
    idle(4);
    chk("shadow_row0_old", {16'b0, got[base + NX - 8]}, 32'h0111);
    chk("slow_last_cmd", {16'b0, got[base + NX - 1]}, 32'h0888);
    rd_chk("status_f2", 2'd1, 32'h0000_0200);
    ack_delay = 0;
    base = xfers;
    wr(2'd0, 32'h0000_0302);
    wait_xfers(base + NX, 200);
    idle(4);
    chk("shadow_row0_new", {16'b0, got[base + NX - 8]}, 32'h01FF);
    chk("shadow_row1_new", {16'b0, got[base + NX - 7]}, 32'h02FF);
    rd_chk("status_f3", 2'd1, 32'h0000_0300);

    // Extra start writes during a frame: only one pending frame
    ack_delay = 10;
    base = xfers;
    wr(2'd0, 32'h0000_0302);
    wr(2'd0, 32'h0000_0302);
    rd_chk("status_pending", 2'd1, 32'h0000_0303);
    wr(2'd0, 32'h0000_0302);
    wait_xfers(base + 2 * NX, 3000);
    idle(300);
    chk("two_frames_only", xfers, base + 2 * NX);
    rd_chk("status_f5", 2'd1, 32'h0000_0500);

    // Timer overrun sets pending; disabling drops a timer-sourced pending
    base = xfers;
    wr(2'd0, 32'h0000_0301);
    st = '0;
    for (int i = 0; i < 200 && !st[1]; i++) bus(2'd1, 32'h0, 1'b0, st);
    chk("timer_pending", {30'b0, st[1:0]}, 32'h3);
    wr(2'd0, 32'h0000_0300);
    wait_xfers(base + NX, 2500);
    idle(300);
    chk("timer_pend_dropped", xfers, base + NX);
    rd_chk("status_f6", 2'd1, 32'h0000_0600);

    // Start-write pending survives a disable
    base = xfers;
    wr(2'd0, 32'h0000_0302);
    wr(2'd0, 32'h0000_0303);
    wr(2'd0, 32'h0000_0300);
    bus(2'd1, 32'h0, 1'b0, st);
    chk("start_pend_kept", {30'b0, st[1:0]}, 32'h3);
    wait_xfers(base + 2 * NX, 4000);
    idle(300);
    chk("start_pend_frames", xfers, base + 2 * NX);
    rd_chk("status_f8", 2'd1, 32'h0000_0800);

    // Reset in the middle of a request
    ack_delay = 40;
    wr(2'd0, 32'h0000_0302);
    idle(5);
    chk("mid_req_stb", {31'b0, m_stb_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stb", {31'b0, m_stb_o}, 32'h0);
    chk("async_rst_mdat", m_dat_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    rd_chk("post_rst_status", 2'd1, 32'h0);
    rd_chk("post_rst_ctrl", 2'd0, 32'h0);
    rd_chk("post_rst_rows0", 2'd2, 32'h0);
    idle(60);
    chk("post_rst_quiet", xfers, 0);

    // Automatic refresh every 100 cycles; 256 frames wrap frame_cnt
    ack_delay = 0;
    wr(2'd0, 32'h0000_0001);
    wait_xfers(256 * NX, 27000);
    idle(5);
    wr(2'd0, 32'h0);
    idle(200);
    chk("refresh_total", xfers, 256 * NX);
    rd_chk("status_wrap", 2'd1, 32'h0);
    if (fstarts.size() >= 256) begin
      chk("period_1", fstarts[1] - fstarts[0], 100);
      chk("period_2", fstarts[2] - fstarts[1], 100);
      chk("period_255", fstarts[255] - fstarts[254], 100);
    end else begin
      chk("frame_starts", fstarts.size(), 256);
    end

`ifdef LED_MATRIX_TEST_EN
    base = xfers;
    wr(2'd0, 32'h0000_0006);
    wait_xfers(base + 13, 200);
    idle(4);
    chk("test_cmd", {16'b0, got[base + 1]}, 32'h0F01);
    chk("test_count", xfers, base + 13);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
